// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
// Optional feature macro used by the decoder files: DECODER_SKID_EN.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction

  // Wide enough to hold HOLD-1 and GAP-1; never narrower than one bit.
  function automatic int cnt_width(input int h, input int g);
    int m;
    m = (h > g) ? h : g;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Single-entry code buffer: holds one accepted code while a pulse is in flight.
// Only instantiated when DECODER_SKID_EN is defined.
module decoder_skid_buf
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CODE_W-1:0] push_code,
  input  logic              pop,
  output logic              full,
  output logic [CODE_W-1:0] code,
  output logic              in_ready
);

  assign in_ready = ~full;

  // push is only issued while empty and pop only while full, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      code <= '0;
    end else if (push) begin
      full <= 1'b1;
      code <= push_code;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: holds a one-hot pulse for HOLD_CYCLES, then a GAP_CYCLES zero gap.
// Define DECODER_SKID_EN to add a one-entry code buffer that chains pulses back to back.
// Handshake: a code transfers on a rising edge where in_valid && in_ready; in_ready never looks at in_valid.
module decoder_3to8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_active,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              xfer;
  logic              load;
  logic              next_avail;
  logic [CODE_W-1:0] next_code;

  assign xfer      = in_valid & in_ready;
  assign dbg_state = state_q;

`ifdef DECODER_SKID_EN
  logic              buf_full;
  logic [CODE_W-1:0] buf_code;
  logic              buf_ready;
  logic              buf_push;
  logic              buf_pop;

  assign in_ready   = ~rst & buf_ready;
  // A buffered code always goes first; otherwise a fresh transfer may start a pulse directly.
  assign next_avail = buf_full | xfer;
  assign next_code  = buf_full ? buf_code : in_code;
  assign buf_pop    = load & buf_full;
  assign buf_push   = xfer & ~(load & ~buf_full);

  decoder_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_code (in_code),
    .pop       (buf_pop),
    .full      (buf_full),
    .code      (buf_code),
    .in_ready  (buf_ready)
  );
`else
  assign in_ready   = ~rst & (state_q == IDLE);
  assign next_avail = xfer;
  assign next_code  = in_code;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: load = next_avail;
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = IDLE;
          load    = next_avail;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          load    = next_avail;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = DRIVE;
      cnt_d   = HOLD_LD;
      code_d  = next_code;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      out        <= '0;
      out_active <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      out        <= (state_d == DRIVE) ? onehot(code_d) : '0;
      out_active <= (state_d == DRIVE);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: schedule-based reference model plus directed vectors.
// Build with DECODER_SKID_EN defined to exercise the buffered variant.
module tb_decoder_3to8_seq;
  import decoder_pkg::*;

  localparam int H = 4;
  localparam int G = 1;
`ifdef DECODER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int DEPTH = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] out;
  logic       out_active;
  logic       busy;
  state_t     dbg_state;

  decoder_3to8_seq #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .out        (out),
    .out_active (out_active),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder seen downstream: {valid, index of the set bit}.
  function automatic logic [3:0] enc8to3(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
    return {(v != 8'h00), idx};
  endfunction

  // ---------------- reference model ----------------
  // Period p is the interval after the p-th rising edge since reset release.
  // Each accepted code gets a start period; the pulse owns H periods, the gap G more.
  int       cyc;
  int       last_start;
  bit [7:0] exp_out  [DEPTH];
  bit       exp_busy [DEPTH];

  function automatic bit model_ready(input int p);
    if (SKID) return last_start <= p;
    return p >= last_start + H + G;
  endfunction

  always @(posedge clk or posedge rst) begin
    int s;
    if (rst) begin
      cyc        = 0;
      last_start = -1000;
      for (int i = 0; i < DEPTH; i++) begin
        exp_out[i]  = 8'h00;
        exp_busy[i] = 1'b0;
      end
    end else begin
      if (in_valid && model_ready(cyc)) begin
        s = cyc + 1;
        if (SKID && (last_start + H + G > s)) s = last_start + H + G;
        for (int k = 0; k < H + G; k++) begin
          if (s + k < DEPTH) begin
            if (k < H) exp_out[s + k] = 8'h01 << in_code;
            exp_busy[s + k] = 1'b1;
          end
        end
        last_start = s;
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        check("rst_out", out, 8'h00);
        check("rst_active", out_active, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
      end else if (cyc < DEPTH) begin
        check("out", out, exp_out[cyc]);
        check("out_active", out_active, exp_out[cyc] != 8'h00);
        check("busy", busy, exp_busy[cyc]);
        check("in_ready", in_ready, model_ready(cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns in the first period of the pulse (or the period after a buffered transfer).
  task automatic send(input logic [2:0] c);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'd0;
    cmp_en   = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("t1_out", out, 8'h00);
    check("t1_active", out_active, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_ready", in_ready, 1'b1);
    tick();

    // Code 5: four cycles of 8'h20, one zero cycle, then ready again.
    send(3'd5);
    for (int k = 0; k < 4; k++) check("t2_pulse", out, 8'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_pulse", out, 8'h20);
    end
    tick();
    check("t2_gap_out", out, 8'h00);
    tick();
    check("t2_ready", in_ready, 1'b1);
    check("t2_idle_busy", busy, 1'b0);

    // Sweep every code through the downstream encoder.
    for (int c = 0; c < 8; c++) begin
      send(3'(c));
      check("t3_enc_drive", enc8to3(out), {1'b1, 3'(c)});
      repeat (H) tick();
      check("t3_enc_gap", enc8to3(out), 4'h0);
    end
    repeat (3) tick();

`ifndef DECODER_SKID_EN
    // Changing in_code mid-pulse is ignored until the block is idle again.
    in_valid = 1'b1;
    in_code  = 3'd3;
    while (!in_ready) tick();
    tick();
    tick();
    in_code = 3'd7;
    check("t4_ready_low", in_ready, 1'b0);
    check("t4_hold_out", out, 8'h08);
    tick();
    check("t4_hold_out2", out, 8'h08);
    repeat (H + G - 1) tick();
    check("t4_late_accept", out, 8'h80);
    in_valid = 1'b0;
    repeat (H + G + 2) tick();
`else
    // Back-to-back codes 2 then 6 chain through the buffer without an idle cycle.
    send(3'd2);
    check("t5_first", out, 8'h04);
    in_valid = 1'b1;
    in_code  = 3'd6;
    tick();
    in_valid = 1'b0;
    check("t5_buf_full_ready", in_ready, 1'b0);
    check("t5_first2", out, 8'h04);
    tick();
    tick();
    check("t5_first4", out, 8'h04);
    tick();
    check("t5_gap", out, 8'h00);
    check("t5_gap_ready", in_ready, 1'b0);
    tick();
    check("t5_second", out, 8'h40);
    check("t5_ready_again", in_ready, 1'b1);
    repeat (3) tick();
    check("t5_second4", out, 8'h40);
    repeat (3) tick();
`endif

    // Reset on the second pulse cycle of code 1 (with code 3 buffered when available).
    send(3'd1);
    if (SKID) begin
      in_valid = 1'b1;
      in_code  = 3'd3;
    end
    tick();
    in_valid = 1'b0;
    check("t6_pre_out", out, 8'h02);
    rst = 1'b1;
    #1;
    check("t6_async_out", out, 8'h00);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_ready", in_ready, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_ready_after", in_ready, 1'b1);
    check("t6_no_stale", out, 8'h00);
    tick();
    send(3'd4);
    check("t6_code4", out, 8'h10);
    repeat (3) tick();
    check("t6_code4_last", out, 8'h10);
    tick();
    check("t6_code4_done", out, 8'h00);
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
